// File: rtl/io_shift_buffer_ctrl_if.sv
// Handshake bundle between io_shift_buffer_ctrl, the core/buffer side and the output stream.
// i_abort exists only when IO_SHIFT_CTRL_ABORT_EN is defined.
interface io_shift_buffer_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 9
);
    logic                  i_start;
    logic [LEN_WIDTH-1:0]  i_len;
    logic                  o_busy;
    logic                  o_load;
    logic                  o_shift;
    logic [DATA_WIDTH-1:0] i_buf_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_last;
    logic [LEN_WIDTH-1:0]  o_count;
    logic                  o_done;
`ifdef IO_SHIFT_CTRL_ABORT_EN
    logic                  i_abort;
`endif

    modport master (
`ifdef IO_SHIFT_CTRL_ABORT_EN
        input  i_abort,
`endif
        input  i_start, i_len, i_buf_data, i_ready,
        output o_busy, o_load, o_shift, o_data, o_valid, o_last, o_count, o_done
    );

    modport slave (
`ifdef IO_SHIFT_CTRL_ABORT_EN
        output i_abort,
`endif
        output i_start, i_len, i_buf_data, i_ready,
        input  o_busy, o_load, o_shift, o_data, o_valid, o_last, o_count, o_done
    );
endinterface

// File: rtl/io_shift_buffer_ctrl.sv
// Loads a result vector into the I/O shift buffer, then drains L tail elements onto a stream.
// Optional abort input enabled by defining IO_SHIFT_CTRL_ABORT_EN.
module io_shift_buffer_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_SIZE  = 256,
    parameter int unsigned LEN_WIDTH  = 9
) (
    input logic                 i_clk,
    input logic                 i_rst,
    io_shift_buffer_ctrl_if.master bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

    localparam logic [LEN_WIDTH-1:0] FifoLen = LEN_WIDTH'(FIFO_SIZE);
    localparam logic [LEN_WIDTH-1:0] One     = LEN_WIDTH'(1);

    state_e               state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] count_q;
    logic                 busy_q, load_q, valid_q, last_q, done_q;

    logic [LEN_WIDTH-1:0] len_eff;
    logic [LEN_WIDTH-1:0] count_inc;
    logic                 abort;
    logic                 xfer;

`ifdef IO_SHIFT_CTRL_ABORT_EN
    assign abort = bus.i_abort;
`else
    assign abort = 1'b0;
`endif

    // Zero or oversize lengths mean a full-buffer drain.
    assign len_eff   = (bus.i_len == '0 || bus.i_len > FifoLen) ? FifoLen : bus.i_len;
    assign count_inc = count_q + One;
    // Abort only matters in LOAD/SEND, and valid_q is high only in SEND.
    assign xfer      = valid_q & bus.i_ready & ~abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        len_q   <= len_eff;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        load_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    load_q <= 1'b0;
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        valid_q <= 1'b1;
                        last_q  <= (len_q == One);
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (xfer) begin
                        count_q <= count_inc;
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            last_q <= (count_inc == len_q - One);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The final beat is not shifted: the buffer is reloaded before the next drain anyway.
    assign bus.o_shift = xfer & ~last_q;
    assign bus.o_data  = valid_q ? bus.i_buf_data : '0;
    assign bus.o_busy  = busy_q;
    assign bus.o_load  = load_q;
    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign bus.o_count = count_q;
    assign bus.o_done  = done_q;
endmodule

// File: tb/tb_io_shift_buffer_ctrl.sv
// Self-checking bench for io_shift_buffer_ctrl: buffer model, beat scoreboard, table of drains.
module tb_io_shift_buffer_ctrl;
    localparam int DW = 16;
    localparam int FS = 256;
    localparam int LW = 9;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    io_shift_buffer_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    io_shift_buffer_ctrl #(
        .DATA_WIDTH(DW),
        .FIFO_SIZE (FS),
        .LEN_WIDTH (LW)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    // Buffer model: load writes element i = i; shift moves every element one step toward the tail.
    logic [DW-1:0] bufm [FS];
    always @(posedge i_clk) begin
        if (bus.o_load) begin
            for (int i = 0; i < FS; i++) bufm[i] <= DW'(i);
        end else if (bus.o_shift) begin
            for (int i = FS - 1; i > 0; i--) bufm[i] <= bufm[i-1];
            bufm[0] <= '0;
        end
    end
    assign bus.i_buf_data = bufm[FS-1];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        logic [LW-1:0] len;
        int            mode;      // 0: ready=1, 1: ready 1,0,0 pattern, 2: random ready
        bit            busy_start;
        int            exp_len;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int load_cnt, shift_cnt, xfer_cnt, done_t, load_t, valid_t, t;
    logic prev_stall;
    logic [DW-1:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, req, t);
        end
    endtask

    task automatic monitor();
        logic ab;
        logic xfer;
        beat_t b;
`ifdef IO_SHIFT_CTRL_ABORT_EN
        ab = bus.i_abort;
`else
        ab = 1'b0;
`endif
        xfer = bus.o_valid && bus.i_ready && !ab;
        if (bus.o_load) chk("load_shift_excl", {31'd0, bus.o_shift}, 32'd0);
        if (prev_stall) begin
            chk("stall_valid", {31'd0, bus.o_valid}, 32'd1);
            chk("stall_data", {16'd0, bus.o_data}, {16'd0, prev_data});
        end
        if (bus.o_valid && !bus.i_ready) chk("stall_shift", {31'd0, bus.o_shift}, 32'd0);
        if (xfer) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'd1, 32'd0);
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", {16'd0, bus.o_data}, {16'd0, b.data});
                chk("beat_last", {31'd0, bus.o_last}, {31'd0, b.last});
                chk("beat_shift", {31'd0, bus.o_shift}, {31'd0, !b.last});
            end
            xfer_cnt++;
        end
        if (bus.o_load) begin
            load_cnt++;
            if (load_t == 0) load_t = t;
        end
        if (bus.o_valid && valid_t == 0) valid_t = t;
        if (bus.o_shift) shift_cnt++;
        prev_stall = bus.o_valid && !bus.i_ready;
        prev_data  = bus.o_data;
    endtask

    task automatic cyc(input logic st, input logic [LW-1:0] ln, input logic rdy, input logic ab);
        @(negedge i_clk);
        bus.i_start = st;
        bus.i_len   = ln;
        bus.i_ready = rdy;
`ifdef IO_SHIFT_CTRL_ABORT_EN
        bus.i_abort = ab;
`else
        if (ab) chk("abort_unsupported", 32'd1, 32'd0);
`endif
        #1;
        monitor();
    endtask

    task automatic arm(input int exp_len);
        exp_q.delete();
        for (int j = 0; j < exp_len; j++) exp_q.push_back('{data: DW'(FS - 1 - j), last: (j == exp_len - 1)});
        load_cnt = 0; shift_cnt = 0; xfer_cnt = 0;
        done_t = 0; load_t = 0; valid_t = 0; t = 0;
        prev_stall = 1'b0;
    endtask

    task automatic run_drain(input vec_t v);
        logic rdy;
        arm(v.exp_len);
        cyc(1'b1, v.len, 1'b1, 1'b0);
        while (done_t == 0 && t < 4 * v.exp_len + 20) begin
            t++;
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = ((t - 2) % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            cyc((v.busy_start && t == 5), LW'(7), rdy, 1'b0);
            if (bus.o_done) begin
                done_t = t;
                chk("done_count", 32'(bus.o_count), 32'(v.exp_len));
            end
        end
        chk("done_seen", {31'd0, done_t != 0}, 32'd1);
        chk("load_once", 32'(load_cnt), 32'd1);
        chk("load_time", 32'(load_t), 32'd1);
        chk("first_valid_time", 32'(valid_t), 32'd2);
        chk("shift_count", 32'(shift_cnt), 32'(v.exp_len - 1));
        chk("beat_count", 32'(xfer_cnt), 32'(v.exp_len));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        if (v.mode == 0) chk("done_time", 32'(done_t), 32'(v.exp_len + 2));
        t++;
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("idle_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("idle_done", {31'd0, bus.o_done}, 32'd0);
        chk("count_hold", 32'(bus.o_count), 32'(v.exp_len));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, bus.o_busy},  32'd0);
        chk({tag, "_load"},  {31'd0, bus.o_load},  32'd0);
        chk({tag, "_shift"}, {31'd0, bus.o_shift}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd0);
        chk({tag, "_last"},  {31'd0, bus.o_last},  32'd0);
        chk({tag, "_done"},  {31'd0, bus.o_done},  32'd0);
        chk({tag, "_count"}, 32'(bus.o_count),     32'd0);
        chk({tag, "_data"},  {16'd0, bus.o_data},  32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{len: 9'd0,   mode: 0, busy_start: 1'b0, exp_len: 256};
        vecs[1] = '{len: 9'd3,   mode: 0, busy_start: 1'b0, exp_len: 3};
        vecs[2] = '{len: 9'd4,   mode: 1, busy_start: 1'b0, exp_len: 4};
        vecs[3] = '{len: 9'd4,   mode: 0, busy_start: 1'b0, exp_len: 4};
        vecs[4] = '{len: 9'd1,   mode: 0, busy_start: 1'b0, exp_len: 1};
        vecs[5] = '{len: 9'd300, mode: 1, busy_start: 1'b0, exp_len: 256};
        vecs[6] = '{len: 9'd6,   mode: 2, busy_start: 1'b1, exp_len: 6};
        vecs[7] = '{len: 9'd256, mode: 0, busy_start: 1'b1, exp_len: 256};

        bus.i_start = 1'b0;
        bus.i_len   = '0;
        bus.i_ready = 1'b0;
`ifdef IO_SHIFT_CTRL_ABORT_EN
        bus.i_abort = 1'b0;
`endif
        t = 0;
        prev_stall = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_all_zero("reset");
        i_rst = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk_all_zero("post_reset");

        foreach (vecs[i]) run_drain(vecs[i]);

        // Reset in the middle of a full drain, after 5 accepted beats.
        arm(256);
        cyc(1'b1, '0, 1'b1, 1'b0);
        while (xfer_cnt < 5 && t < 20) begin
            t++;
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        chk("pre_reset_beats", 32'(xfer_cnt), 32'd5);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1 chk_all_zero("mid_reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        run_drain('{len: 9'd2, mode: 0, busy_start: 1'b0, exp_len: 2});

`ifdef IO_SHIFT_CTRL_ABORT_EN
        arm(10);
        cyc(1'b1, 9'd10, 1'b1, 1'b0);
        while (xfer_cnt < 4 && t < 20) begin
            t++;
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        t++;
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("abort_shift", {31'd0, bus.o_shift}, 32'd0);
        t++;
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("abort_done", {31'd0, bus.o_done}, 32'd1);
        chk("abort_count", 32'(bus.o_count), 32'd4);
        chk("abort_beats", 32'(xfer_cnt), 32'd4);
        chk("abort_valid", {31'd0, bus.o_valid}, 32'd0);
        exp_q.delete();
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("abort_idle", {31'd0, bus.o_busy}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_shift_buffer_ctrl.md
# io_shift_buffer_ctrl

Sequencing controller for the I/O shift buffer. It issues the parallel load of a result vector into the buffer. It then drains a programmable number of elements out of the buffer tail onto a valid/ready stream, asserting the buffer shift once per accepted beat. It sits between the compute core, which supplies the result vector and the start pulse, and the downstream output stream consumer.

## Interface
- DATA_WIDTH, 16, element width; must match the buffer.
- FIFO_SIZE, 256, buffer depth in elements.
- LEN_WIDTH, 9, width of length/count fields; requires 2^LEN_WIDTH > FIFO_SIZE.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_len  in  LEN_WIDTH  elements to drain; sampled with i_start; 0 or > FIFO_SIZE means FIFO_SIZE.
- o_busy  out  1  high in LOAD, SEND, DONE.
- o_load  out  1  buffer load strobe.
- o_shift  out  1  buffer shift strobe.
- i_buf_data  in  DATA_WIDTH  buffer tail element (element FIFO_SIZE-1).
- o_data  out  DATA_WIDTH  stream data.
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready.
- o_last  out  1  marks the final beat; qualified by o_valid.
- o_count  out  LEN_WIDTH  beats accepted in the current/last drain.
- o_done  out  1  one-cycle completion pulse.
- i_abort  in  1  present only with IO_SHIFT_CTRL_ABORT_EN.

## Operation
- States: IDLE, LOAD, SEND, DONE. Reset state is IDLE.
- All registered state and outputs reset to 0: o_busy, o_load, o_shift, o_valid, o_last, o_done, and o_count.
- IDLE:
  - i_start=1 latches the effective length L into len_r.
  - Clears o_count.
  - Moves to LOAD.
- LOAD:
  - o_load=1 for exactly one cycle.
  - Always moves to SEND.
- SEND:
  - o_valid=1 and o_data=i_buf_data (combinational pass-through).
  - o_last=1 when o_count == L-1.
- A transfer is o_valid & i_ready. On each transfer, o_count increments.
  - Not the last beat: o_shift=1 in the same cycle, combinationally from i_ready.
  - Last beat: o_shift stays 0 and the state moves to DONE.
- Without a transfer, o_shift=0 and o_data holds steady, because the buffer is not shifted.
- DONE:
  - o_done=1 for one cycle.
  - Moves to IDLE.
  - o_count holds L until the next start.
- Beats are emitted in tail-first order: buffer element FIFO_SIZE-1, then FIFO_SIZE-2, and so on.
- i_start outside IDLE is ignored; it is not queued.
- o_load and o_shift are never high in the same cycle.
- Downstream stream rules:
  - Once o_valid rises it stays high until the transfer completes.
  - o_data must not change while o_valid=1 and i_ready=0.
- Reset mid-drain returns to IDLE immediately. All outputs drop to 0 asynchronously. Buffer contents are the buffer's own concern.

## Timing
- Edge k samples i_start=1.
- Cycle k+1: o_load=1.
- Cycle k+2: o_valid=1, with o_data equal to the loaded vector's element FIFO_SIZE-1.
- With i_ready held at 1: one beat per cycle, L beats over cycles k+2 .. k+L+1, o_done in cycle k+L+2, IDLE from cycle k+L+3.
- Earliest re-start is the cycle o_busy is low, giving a minimum period of L+3 cycles.
- Combinational paths: i_ready -> o_shift and i_buf_data -> o_data. All other outputs are registered-state decodes.

## Configuration
- IO_SHIFT_CTRL_ABORT_EN defined:
  - Adds the i_abort input.
  - i_abort=1 in LOAD or SEND forces DONE at the next edge, suppressing o_shift and the transfer in that cycle.
  - o_done pulses; o_count holds the beats accepted so far.
  - i_abort in IDLE or DONE has no effect.
- Undefined: no i_abort port, and drains always run to L beats.

## Test plan
- Full drain, back-to-back: load vector with element i = i, i_len=0, i_ready=1.
  - Expect o_load at k+1, 256 beats with values 255..0 on consecutive cycles, o_last on value 0, o_done at k+258, o_count=256.
- Partial drain: i_len=3.
  - Expect beats 255, 254, 253, o_last on 253, exactly 2 o_shift pulses, o_count=3.
- Backpressure: i_len=4, i_ready toggling 1,0,0,1,...
  - Expect o_data stable and o_shift=0 on stalled cycles, and a beat sequence identical to the no-stall case.
- Start while busy: second i_start during SEND.
  - Expect it ignored: no extra o_load, L and o_count unaffected.
- Reset mid-SEND after 5 beats.
  - Expect all outputs 0 immediately.
  - A new start with i_len=2 then works normally.
- With IO_SHIFT_CTRL_ABORT_EN: i_len=10, i_abort after 4 beats.
  - Expect no 5th transfer, o_done the next cycle, o_count=4.
